axi_ocp_wr_burst_gen: RTL and testbench
=======================================

Name: axi_ocp_wr_burst_gen

Overview:
Downstream stage of the AXI write front end in the AXI-to-OCP interconnect.
- Consumes one assembled write packet at a time (id, awlen, address, 16 data words) over a valid/hold handshake.
- Replays the packet as an OCP write burst of awlen+1 beats, one data word per beat, advanced by SCmdAccept.
- Reports completion per packet with its AXI id, so the response path can retire it.

Parameters:
- ADDR_W, 32, OCP/AXI address width.
- DATA_W, 32, beat data width; packet data field is 16*DATA_W.
- ADDR_INCR, 4, byte increment of MAddr per beat (INCR burst).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- pkt_vld  in  1  upstream packet valid.
- pkt  in  8+ADDR_W+16*DATA_W  {id[3:0], length[3:0], addr, d15..d0}, d0 in LSBs.
- hold_out  out  1  to upstream hold_in; packet is consumed on pkt_vld & !hold_out.
- MCmd  out  3  OCP command: 3'b000 IDLE, 3'b001 WR.
- MAddr  out  ADDR_W  beat address.
- MData  out  DATA_W  beat data.
- MBurstLength  out  5  length+1, constant for the whole burst.
- MReqLast  out  1  high on the final beat.
- SCmdAccept  in  1  slave accepts the current beat.
- SResp  in  2  OCP response (NULL=00, DVA=01, ERR=11); used only with OCP_WR_RESP_EN.
- wr_done  out  1  one-cycle completion pulse.
- wr_done_id  out  4  id of the completed packet, valid with wr_done.
- wr_done_err  out  1  error flag, valid with wr_done.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - MCmd=IDLE; MAddr, MData, MBurstLength, MReqLast = 0.
  - wr_done, wr_done_id, wr_done_err = 0.
  - Beat counter = 0; captured packet discarded.
  - hold_out=1 combinationally while rst=0.
- hold_out = (state != IDLE) | !rst.
- State machine:
  - IDLE: on pkt_vld & !hold_out, register the whole pkt, set beat=0, go to BURST.
  - BURST: MCmd=WR, MAddr=addr+beat*ADDR_INCR (modulo 2^ADDR_W), MData=d[beat], MBurstLength=length+1, MReqLast=(beat==length).
    - SCmdAccept=0: all M* outputs held stable.
    - SCmdAccept=1 with beat<length: beat+1 next cycle.
    - SCmdAccept=1 with beat==length: go to IDLE (or WAIT_RESP, see feature). M* outputs return to 0/IDLE next cycle.
  - Without the feature, wr_done pulses in the cycle after last-beat acceptance, with wr_done_id=id and wr_done_err=0.
- Latency: packet captured at edge N; first WR beat is presented in cycle N+1. An always-accepting slave gives length+1 beat cycles and 1 idle cycle between back-to-back packets.
- Boundary conditions:
  - length=0: single beat, MReqLast=1 on it, MBurstLength=1.
  - length=15: 16 beats; d15 sent last.
  - Address wraps modulo 2^ADDR_W with no error.
  - pkt_vld while busy: ignored, no capture; upstream is held.
  - Reset mid-burst: burst abandoned immediately, no wr_done, MCmd=IDLE next cycle.
  - pkt changing while pkt_vld=1 and hold_out=1: no effect.

Optional Feature:
OCP_WR_RESP_EN
- Defined:
  - After last-beat acceptance, enter WAIT_RESP; MCmd=IDLE and hold_out=1 there.
  - Stay in WAIT_RESP while SResp=NULL.
  - SResp=DVA: wr_done pulses next cycle with wr_done_err=0; return to IDLE.
  - SResp=ERR: same, with wr_done_err=1.
  - Reset in WAIT_RESP: to IDLE, no wr_done.
- Undefined: SResp is ignored (port still present), there is no WAIT_RESP state, and wr_done_err is tied to 0.

Test Plan:
- Reset/idle: rst=0 for 3 cycles with pkt_vld=1 -> hold_out=1, MCmd=000, wr_done=0; after release, hold_out=0.
- Single beat: id=4'h3, length=0, addr=32'h1000, d0=32'hA5A5_0001, SCmdAccept=1 -> one beat with MCmd=001, MAddr=32'h1000, MData=32'hA5A5_0001, MBurstLength=1, MReqLast=1; wr_done=1 with wr_done_id=3 the next cycle.
- Full burst with stalls: length=15, addr=32'h2000, dN=N, SCmdAccept low every other cycle -> 16 beats, MAddr 32'h2000..32'h203C, MData 0..15, outputs stable during stalls, MReqLast only on MAddr=32'h203C.
- Back-to-back: two packets (id 1, length 3; id 2, length 1) presented continuously -> 6 beats total, with exactly 1 IDLE cycle between bursts and wr_done ids 1 then 2.
- Wrap and mid-burst reset:
  - addr=32'hFFFF_FFF8, length=3 -> MAddr FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
  - Second run: rst=0 at beat 2 -> MCmd=000 next cycle, no wr_done.
- OCP_WR_RESP_EN: length=1, SResp NULL for 5 cycles then ERR -> hold_out=1 throughout; wr_done=1 with wr_done_err=1 the cycle after ERR; then IDLE.

Source files
------------

// File: rtl/axi_ocp_wr_burst_gen.sv
// axi_ocp_wr_burst_gen
//   Takes one assembled AXI write packet at a time and replays it as an OCP
//   INCR write burst of length+1 beats, one data word per beat, advancing on
//   SCmdAccept. Each packet is retired with a one-cycle wr_done pulse that
//   carries the packet's AXI id.
//
//   Optional build macro: OCP_WR_RESP_EN
//     When defined, the block waits for a non-NULL SResp after the last
//     beat. Completion is reported only after that response, and ERR sets
//     wr_done_err. When undefined, SResp is ignored and wr_done_err is 0.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   pkt_vld, pkt        packet in: {id[3:0], length[3:0], addr, d15..d0}
//   hold_out            back-pressure to upstream (consume = pkt_vld & !hold_out)
//   MCmd, MAddr, MData,
//   MBurstLength,
//   MReqLast            OCP master request (registered)
//   SCmdAccept, SResp   OCP slave accept / response
//   wr_done, wr_done_id,
//   wr_done_err         completion pulse with id and error flag
module axi_ocp_wr_burst_gen #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_INCR = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pkt_vld,
    input  logic [8+ADDR_W+16*DATA_W-1:0]  pkt,
    output logic                           hold_out,
    output logic [2:0]                     MCmd,
    output logic [ADDR_W-1:0]              MAddr,
    output logic [DATA_W-1:0]              MData,
    output logic [4:0]                     MBurstLength,
    output logic                           MReqLast,
    input  logic                           SCmdAccept,
    input  logic [1:0]                     SResp,
    output logic                           wr_done,
    output logic [3:0]                     wr_done_id,
    output logic                           wr_done_err
);

    localparam int DW16 = 16 * DATA_W;
    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST
`ifdef OCP_WR_RESP_EN
        , ST_WAIT_RESP
`endif
    } state_t;

    state_t            state;
    logic [3:0]        id_r;
    logic [3:0]        len_r;
    logic [3:0]        beat;
    // Words still to be sent; shifted down one word per accepted beat so the
    // next beat's data is always in the low bits.
    logic [DW16-1:0]   data_r;

    logic [3:0]        pkt_id;
    logic [3:0]        pkt_len;
    logic [ADDR_W-1:0] pkt_addr;

    assign pkt_id   = pkt[DW16+ADDR_W+4 +: 4];
    assign pkt_len  = pkt[DW16+ADDR_W   +: 4];
    assign pkt_addr = pkt[DW16          +: ADDR_W];

    assign hold_out = (state != ST_IDLE) || !rst;

`ifdef OCP_WR_RESP_EN
    logic err_r;
    assign wr_done_err = err_r;
`else
    logic sresp_unused;
    assign sresp_unused = ^SResp;
    assign wr_done_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            id_r         <= '0;
            len_r        <= '0;
            beat         <= '0;
            data_r       <= '0;
            MCmd         <= CMD_IDLE;
            MAddr        <= '0;
            MData        <= '0;
            MBurstLength <= '0;
            MReqLast     <= 1'b0;
            wr_done      <= 1'b0;
            wr_done_id   <= '0;
`ifdef OCP_WR_RESP_EN
            err_r        <= 1'b0;
`endif
        end else begin
            wr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // hold_out is low here (rst high, state idle), so pkt_vld alone consumes.
                    if (pkt_vld) begin
                        id_r         <= pkt_id;
                        len_r        <= pkt_len;
                        beat         <= '0;
                        data_r       <= pkt[DW16-1:0] >> DATA_W;
                        MCmd         <= CMD_WR;
                        MAddr        <= pkt_addr;
                        MData        <= pkt[DATA_W-1:0];
                        MBurstLength <= {1'b0, pkt_len} + 5'd1;
                        MReqLast     <= (pkt_len == 4'd0);
                        state        <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (SCmdAccept) begin
                        if (beat == len_r) begin
                            MCmd         <= CMD_IDLE;
                            MAddr        <= '0;
                            MData        <= '0;
                            MBurstLength <= '0;
                            MReqLast     <= 1'b0;
`ifdef OCP_WR_RESP_EN
                            state        <= ST_WAIT_RESP;
`else
                            state        <= ST_IDLE;
                            wr_done      <= 1'b1;
                            wr_done_id   <= id_r;
`endif
                        end else begin
                            beat     <= beat + 4'd1;
                            MAddr    <= MAddr + ADDR_W'(ADDR_INCR);
                            MData    <= data_r[DATA_W-1:0];
                            data_r   <= data_r >> DATA_W;
                            MReqLast <= ((beat + 4'd1) == len_r);
                        end
                    end
                end
`ifdef OCP_WR_RESP_EN
                ST_WAIT_RESP: begin
                    if (SResp != 2'b00) begin
                        wr_done    <= 1'b1;
                        wr_done_id <= id_r;
                        err_r      <= (SResp == 2'b11);
                        state      <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ocp_wr_burst_gen.sv
module tb_axi_ocp_wr_burst_gen;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ADDR_INCR = 4;
    localparam int PKT_W     = 8 + ADDR_W + 16*DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pkt_vld = 1'b0;
    logic [PKT_W-1:0]  pkt = '0;
    logic              hold_out;
    logic [2:0]        MCmd;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MData;
    logic [4:0]        MBurstLength;
    logic              MReqLast;
    logic              SCmdAccept = 1'b0;
    logic [1:0]        SResp = 2'b00;
    logic              wr_done;
    logic [3:0]        wr_done_id;
    logic              wr_done_err;

    axi_ocp_wr_burst_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .ADDR_INCR(ADDR_INCR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_vld     (pkt_vld),
        .pkt         (pkt),
        .hold_out    (hold_out),
        .MCmd        (MCmd),
        .MAddr       (MAddr),
        .MData       (MData),
        .MBurstLength(MBurstLength),
        .MReqLast    (MReqLast),
        .SCmdAccept  (SCmdAccept),
        .SResp       (SResp),
        .wr_done     (wr_done),
        .wr_done_id  (wr_done_id),
        .wr_done_err (wr_done_err)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The expected burst is a list of beats computed straight from the packet:
    // beat i goes to addr+i*ADDR_INCR with word d[i]; the front is popped on
    // every accepted beat.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic [4:0]  blen;
    } beat_t;

    beat_t       exp_q[$];
    bit          m_wait = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;
    logic [3:0]  m_id   = '0;
    logic [3:0]  cur_id = '0;
    int unsigned caps   = 0;

    // collector of accepted beats for the directed cases
    int unsigned col_beats, col_lasts;
    logic [31:0] col_addr, col_data;
    logic [4:0]  col_blen;

    function automatic bit m_busy();
        return (exp_q.size() != 0) || m_wait;
    endfunction

    task automatic model_step();
        bit nd;
        nd = 1'b0;
        if (MCmd === 3'b001 && SCmdAccept && rst) begin
            col_beats++;
            col_addr = MAddr;
            col_data = MData;
            col_blen = MBurstLength;
            if (MReqLast) col_lasts++;
        end
        if (!rst) begin
            exp_q.delete();
            m_wait = 1'b0;
        end else if (m_wait) begin
            if (SResp != 2'b00) begin
                m_wait = 1'b0;
                nd     = 1'b1;
                m_err  = (SResp == 2'b11);
            end
        end else if (exp_q.size() != 0) begin
            if (SCmdAccept) begin
                bit lst;
                lst = exp_q[0].last;
                void'(exp_q.pop_front());
                if (lst) begin
`ifdef OCP_WR_RESP_EN
                    m_wait = 1'b1;
`else
                    nd    = 1'b1;
                    m_err = 1'b0;
`endif
                end
            end
        end else if (pkt_vld) begin
            int unsigned len;
            logic [31:0] base;
            len    = int'(pkt[PKT_W-5 -: 4]);
            base   = pkt[16*DATA_W +: ADDR_W];
            cur_id = pkt[PKT_W-1 -: 4];
            for (int unsigned i = 0; i <= len; i++) begin
                beat_t b;
                b.addr = base + i * ADDR_INCR;
                b.data = pkt[i*DATA_W +: DATA_W];
                b.last = (i == len);
                b.blen = 5'(len + 1);
                exp_q.push_back(b);
            end
            caps++;
        end
        m_done = nd;
        m_id   = cur_id;
    endtask

    task automatic model_check();
        chk("hold_out", hold_out, m_busy() || !rst);
        if (exp_q.size() != 0) begin
            chk("MCmd", MCmd, 3'b001);
            chk("MAddr", MAddr, exp_q[0].addr);
            chk("MData", MData, exp_q[0].data);
            chk("MBurstLength", MBurstLength, exp_q[0].blen);
            chk("MReqLast", MReqLast, exp_q[0].last);
        end else begin
            chk("MCmd_idle", MCmd, 3'b000);
            chk("MAddr_idle", MAddr, 0);
            chk("MReqLast_idle", MReqLast, 0);
            chk("MBurstLength_idle", MBurstLength, 0);
        end
        chk("wr_done", wr_done, m_done);
        if (m_done) begin
            chk("wr_done_id", wr_done_id, m_id);
            chk("wr_done_err", wr_done_err, m_err);
        end
    endtask

    // one clock: model consumes the inputs seen at the edge, then outputs are checked
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    function automatic logic [PKT_W-1:0] build(input logic [3:0] id, input logic [3:0] len,
                                               input logic [31:0] addr, input logic [31:0] dbase);
        logic [PKT_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < 16; i++) p[i*DATA_W +: DATA_W] = dbase + i;
        p[16*DATA_W +: ADDR_W] = addr;
        p[PKT_W-5 -: 4] = len;
        p[PKT_W-1 -: 4] = id;
        return p;
    endfunction

    function automatic logic acc(input int unsigned mode, input int unsigned k);
        case (mode)
            1:       return (k % 2) == 1;
            2:       return (k % 3) == 2;
            default: return 1'b1;
        endcase
    endfunction

    typedef struct {
        logic [3:0]  id;
        logic [3:0]  len;
        logic [31:0] addr;
        logic [31:0] dbase;
        int unsigned mode;
        int unsigned exp_beats;
        logic [31:0] exp_last_addr;
        logic [31:0] exp_last_data;
        logic [4:0]  exp_blen;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'h3, 4'd0,  32'h0000_1000, 32'hA5A5_0001, 0, 1,  32'h0000_1000, 32'hA5A5_0001, 5'd1};
        vecs[1] = '{4'h5, 4'd15, 32'h0000_2000, 32'h0000_0000, 1, 16, 32'h0000_203C, 32'h0000_000F, 5'd16};
        vecs[2] = '{4'h7, 4'd3,  32'hFFFF_FFF8, 32'hDEAD_0000, 0, 4,  32'h0000_0004, 32'hDEAD_0003, 5'd4};
        vecs[3] = '{4'hF, 4'd7,  32'h0000_0100, 32'h0000_0050, 2, 8,  32'h0000_011C, 32'h0000_0057, 5'd8};

        // reset with pkt_vld asserted
        rst = 1'b0; pkt_vld = 1'b1; pkt = build(4'h1, 4'd2, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_hold", hold_out, 1);
            chk("rst_mcmd", MCmd, 3'b000);
            chk("rst_done", wr_done, 0);
        end
        pkt_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_release_hold", hold_out, 0);

        // table-driven single packets
        for (int v = 0; v < 4; v++) begin
            bit got_done;
            logic [3:0] did;
            int unsigned k;
            col_beats = 0; col_lasts = 0; col_addr = '0; col_data = '0; col_blen = '0;
            pkt = build(vecs[v].id, vecs[v].len, vecs[v].addr, vecs[v].dbase);
            pkt_vld = 1'b1; SCmdAccept = 1'b0;
            cyc();
            pkt_vld = 1'b0;
            got_done = 1'b0; did = '0; k = 0;
            while (!got_done && k < 60) begin
                SCmdAccept = acc(vecs[v].mode, k);
                cyc();
                if (wr_done) begin got_done = 1'b1; did = wr_done_id; end
                k++;
            end
            SCmdAccept = 1'b0;
            chk($sformatf("vec%0d_done", v), got_done, 1);
            chk($sformatf("vec%0d_id", v), did, vecs[v].id);
            chk($sformatf("vec%0d_beats", v), col_beats, vecs[v].exp_beats);
            chk($sformatf("vec%0d_lasts", v), col_lasts, 1);
            chk($sformatf("vec%0d_last_addr", v), col_addr, vecs[v].exp_last_addr);
            chk($sformatf("vec%0d_last_data", v), col_data, vecs[v].exp_last_data);
            chk($sformatf("vec%0d_blen", v), col_blen, vecs[v].exp_blen);
            cyc();
        end

        // back-to-back packets presented continuously
        begin
            int unsigned c0, wr_cnt, gap, dones, k;
            bit seen_wr, seen_gap_end;
            logic [3:0] ids[2];
            int unsigned idle_run;
            c0 = caps; wr_cnt = 0; gap = 0; dones = 0; k = 0; idle_run = 0;
            seen_wr = 1'b0; seen_gap_end = 1'b0;
            ids[0] = '0; ids[1] = '0;
            SCmdAccept = 1'b1;
            pkt = build(4'h1, 4'd3, 32'h3000, 32'h100);
            pkt_vld = 1'b1;
            while (dones < 2 && k < 40) begin
                cyc();
                if (caps - c0 == 1) pkt = build(4'h2, 4'd1, 32'h4000, 32'h200);
                if (caps - c0 >= 2) pkt_vld = 1'b0;
                if (MCmd == 3'b001) begin
                    if (seen_wr && idle_run != 0 && !seen_gap_end) begin
                        gap = idle_run; seen_gap_end = 1'b1;
                    end
                    seen_wr = 1'b1; wr_cnt++; idle_run = 0;
                end else if (seen_wr) begin
                    idle_run++;
                end
                if (wr_done) begin
                    if (dones < 2) ids[dones] = wr_done_id;
                    dones++;
                end
                k++;
            end
            pkt_vld = 1'b0;
            chk("b2b_dones", dones, 2);
            chk("b2b_beats", wr_cnt, 6);
            chk("b2b_gap", gap, 1);
            chk("b2b_id0", ids[0], 4'h1);
            chk("b2b_id1", ids[1], 4'h2);
        end

        // wrap then reset mid-burst at beat 2
        begin
            int unsigned dn;
            dn = 0;
            SCmdAccept = 1'b1;
            pkt = build(4'h6, 4'd3, 32'hFFFF_FFF8, 32'h7000);
            pkt_vld = 1'b1;
            cyc();
            pkt_vld = 1'b0;
            cyc();
            cyc();
            chk("mid_beat2_addr", MAddr, 32'h0000_0000);
            chk("mid_beat2_cmd", MCmd, 3'b001);
            rst = 1'b0;
            cyc();
            chk("mid_rst_cmd", MCmd, 3'b000);
            rst = 1'b1;
            for (int i = 0; i < 4; i++) begin
                cyc();
                if (wr_done) dn++;
            end
            chk("mid_rst_no_done", dn, 0);
        end

`ifdef OCP_WR_RESP_EN
        begin
            SCmdAccept = 1'b1; SResp = 2'b00;
            pkt = build(4'h9, 4'd1, 32'h40, 32'h1);
            pkt_vld = 1'b1;
            cyc();
            pkt_vld = 1'b0;
            cyc();
            cyc();
            for (int i = 0; i < 5; i++) begin
                cyc();
                chk("resp_wait_hold", hold_out, 1);
                chk("resp_wait_cmd", MCmd, 3'b000);
            end
            SResp = 2'b11;
            cyc();
            chk("resp_done", wr_done, 1);
            chk("resp_err", wr_done_err, 1);
            chk("resp_id", wr_done_id, 4'h9);
            SResp = 2'b00;
            cyc();
            chk("resp_idle_hold", hold_out, 0);
        end
`endif

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [575:0] tmp;
            int unsigned r;
            for (int i = 0; i < 18; i++) tmp[i*32 +: 32] = $urandom;
            pkt = tmp[PKT_W-1:0];
            pkt_vld = 1'($urandom % 2);
            SCmdAccept = ($urandom % 10) < 6;
            rst = ($urandom % 100) != 0;
            r = $urandom % 8;
            SResp = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : 2'b00;
            cyc();
        end
        rst = 1'b1; pkt_vld = 1'b0; SCmdAccept = 1'b1; SResp = 2'b01;
        for (int i = 0; i < 40 && m_busy(); i++) cyc();
        cyc();
        chk("drain_idle", hold_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
